mem_stage_p: RTL and testbench
==============================

MEM_STAGE_P -- requirements
Module: mem_stage_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data/address-result width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, meaning memory words (power of 2); ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter REG_W, default 3, meaning destination-register index width.
REQ-004 SHALL have ports as listed:
- clock  in  1  sole clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- inValid  in  1  stage input holds a real instruction.
- stall  in  1  hold stage; no write, outputs frozen.
- flush  in  1  kill the instruction being registered.
- MemRead, MemWrite, Branch, Zero, RegWrite  in  1 each  control.
- byteEn  in  DATA_W/8  byte lanes for stores.
- resultULA  in  DATA_W  ALU result / word address.
- writeDataMEM  in  DATA_W  store data.
- shiftPC  in  DATA_W  branch target.
- RegDst  in  REG_W  destination register.
- PCSrc  out  1  take branch (combinational).
- outValid  out  1  registered valid.
- outputDataReadMEM  out  DATA_W  load data.
- outputMemULA  out  DATA_W  registered resultULA.
- outputShiftPC  out  DATA_W  registered shiftPC.
- outputRegDst  out  REG_W  registered RegDst.
- outRegWrite  out  1  registered RegWrite AND valid.
- addrError  out  1  registered out-of-range access flag.

Function
REQ-005 SHALL drive PCSrc = inValid & Branch & Zero & !flush, combinationally, independent of stall.
REQ-006 SHALL accept an instruction ("fire") on a rising edge when inValid & !stall & !flush.
REQ-007 SHALL treat resultULA as a word address; in range iff resultULA < DEPTH.
REQ-008 SHALL write writeDataMEM to mem[resultULA] on fire with MemWrite and in-range address; no write otherwise.
REQ-009 SHALL register outputs one cycle after fire: read latency exactly 1 cycle, aligned with outputMemULA/outputRegDst/outputShiftPC.
REQ-010 SHALL return the newly written data when MemRead and MemWrite fire together on one address (write-first).
REQ-011 SHALL drive outputDataReadMEM = 0 when the registered instruction had MemRead = 0 or an out-of-range address.
REQ-012 SHALL set addrError = 1 for one output slot when a fired instruction with MemRead or MemWrite is out of range; write suppressed.
REQ-013 SHALL hold every output and memory unchanged while stall = 1 and flush = 0.
REQ-014 SHALL, on flush (priority over stall), clear outValid, outRegWrite and addrError at the next edge and suppress any write.
REQ-015 SHALL set outValid = 0 on an edge with inValid = 0 and stall = 0 (bubble); other data outputs may hold stale values.

Reset
REQ-016 SHALL, on resetN low, asynchronously clear outValid, outRegWrite, addrError, outputDataReadMEM, outputMemULA, outputShiftPC, outputRegDst to 0.
REQ-017 SHALL leave memory contents unreset; reset mid-store SHALL not guarantee that store.
REQ-018 SHALL resume firing on the first rising edge after resetN deasserts.

Configuration
REQ-019 SHALL, with MEM_BYTE_WRITE_EN defined, write only byte lanes with byteEn[i] = 1; with byteEn = 0 no write but addrError still evaluated.
REQ-020 SHALL, without MEM_BYTE_WRITE_EN, keep byteEn as a port, ignore it, and write full words.

Structure
REQ-021 SHALL place default parameter constants (DATA_W, DEPTH, REG_W) and the addrError/valid pipeline-record type in package mem_stage_pkg.
REQ-022 SHALL instantiate sub-module mem_stage_ram: single-port synchronous RAM, write-first, byte-lane write enables.

Verification (DATA_W=16, DEPTH=256)
REQ-023 Store 16'hBEEF at 16'h0010, then load 16'h0010 -> outputDataReadMEM = 16'hBEEF, outValid = 1 one cycle after load fires.
REQ-024 MemRead = MemWrite = 1, addr 16'h000F, data 16'h0001 -> outputDataReadMEM = 16'h0001 same slot.
REQ-025 Load 16'h0100 -> addrError = 1, outputDataReadMEM = 0; store 16'h0100 leaves mem[16'h0000] unchanged.
REQ-026 Branch = 1, Zero = 1, inValid = 1 -> PCSrc = 1 immediately; Zero = 0 -> PCSrc = 0; stall asserted 3 cycles -> outputs frozen; flush with stall -> outValid = 0 next edge.
REQ-027 With MEM_BYTE_WRITE_EN: mem = 16'h1234, store 16'hABCD, byteEn = 2'b01 -> reload 16'h12CD; without macro -> 16'hABCD.
REQ-028 resetN pulsed low mid-cycle -> all outputs 0 before next edge; store fired after release reads back correctly.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared defaults and pipeline-record type for the memory stage.
//   DATA_W_DEF / DEPTH_DEF / REG_W_DEF : default parameter values
//   pipeRec_t : registered valid / regWrite / addrError flags of one output slot
package mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 256;
    localparam int REG_W_DEF  = 3;

    typedef struct packed {
        logic valid;
        logic regWrite;
        logic addrError;
    } pipeRec_t;

endpackage

// File: rtl/mem_stage_ram.sv
// mem_stage_ram: single-port synchronous RAM, write-first, byte-lane write enables.
//   clock  : rising-edge clock
//   en     : access enable; rdData updates only when set
//   laneWe : per-byte write enables (already qualified by the caller)
//   addr   : word address
//   wrData : write data
//   rdData : registered read data (1-cycle latency, shows newly written bytes)
module mem_stage_ram
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LANES  = DATA_W / 8
) (
    input  logic              clock,
    input  logic              en,
    input  logic [LANES-1:0]  laneWe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    // Old word with enabled lanes replaced: both the stored value and the write-first read value.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < LANES; i++)
            if (laneWe[i]) merged[8*i +: 8] = wrData[8*i +: 8];
    end

    always_ff @(posedge clock) begin
        if (|laneWe) mem[addr] <= merged;
        if (en) rdData <= merged;
    end

endmodule

// File: rtl/mem_stage_p.sv
// mem_stage_p: pipeline memory stage (data RAM access, branch decision, output registers).
//   Ports: clock, resetN (async active-low); inValid/stall/flush handshake;
//   MemRead/MemWrite/Branch/Zero/RegWrite control; byteEn store lanes;
//   resultULA word address, writeDataMEM store data, shiftPC branch target, RegDst;
//   PCSrc (combinational), registered outValid/outRegWrite/addrError and data outputs.
//   Macro MEM_BYTE_WRITE_EN: honour byteEn on stores; otherwise stores write full words.
module mem_stage_p
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                inValid,
    input  logic                stall,
    input  logic                flush,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                Branch,
    input  logic                Zero,
    input  logic                RegWrite,
    input  logic [DATA_W/8-1:0] byteEn,
    input  logic [DATA_W-1:0]   resultULA,
    input  logic [DATA_W-1:0]   writeDataMEM,
    input  logic [DATA_W-1:0]   shiftPC,
    input  logic [REG_W-1:0]    RegDst,
    output logic                PCSrc,
    output logic                outValid,
    output logic [DATA_W-1:0]   outputDataReadMEM,
    output logic [DATA_W-1:0]   outputMemULA,
    output logic [DATA_W-1:0]   outputShiftPC,
    output logic [REG_W-1:0]    outputRegDst,
    output logic                outRegWrite,
    output logic                addrError
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LANES  = DATA_W / 8;

    logic             fire;
    logic             inRange;
    logic             doWrite;
    logic             readOk;
    logic [LANES-1:0] laneWe;
    logic [DATA_W-1:0] ramData;
    pipeRec_t         rec;

    assign fire    = resetN & inValid & ~stall & ~flush;
    // In range iff every address bit above the RAM index is zero.
    assign inRange = ~|(resultULA >> ADDR_W);
    assign doWrite = fire & MemWrite & inRange;
    assign PCSrc   = inValid & Branch & Zero & ~flush;

`ifdef MEM_BYTE_WRITE_EN
    assign laneWe = byteEn & {LANES{doWrite}};
`else
    logic unusedByteEn;
    assign unusedByteEn = ^byteEn;
    assign laneWe = {LANES{doWrite}};
`endif

    mem_stage_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ram (
        .clock (clock),
        .en    (fire),
        .laneWe(laneWe),
        .addr  (resultULA[ADDR_W-1:0]),
        .wrData(writeDataMEM),
        .rdData(ramData)
    );

    // RAM output register carries no reset; readOk masks it to zero after reset,
    // for non-loads and for out-of-range loads.
    assign outputDataReadMEM = readOk ? ramData : '0;
    assign outValid    = rec.valid;
    assign outRegWrite = rec.regWrite;
    assign addrError   = rec.addrError;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rec           <= '0;
            readOk        <= 1'b0;
            outputMemULA  <= '0;
            outputShiftPC <= '0;
            outputRegDst  <= '0;
        end else if (flush) begin
            rec <= '0;
        end else if (!stall) begin
            rec <= '{valid:     inValid,
                     regWrite:  inValid & RegWrite,
                     addrError: inValid & (MemRead | MemWrite) & ~inRange};
            if (inValid) begin
                readOk        <= MemRead & inRange;
                outputMemULA  <= resultULA;
                outputShiftPC <= shiftPC;
                outputRegDst  <= RegDst;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_p.sv
// tb_mem_stage_p: randomized scoreboard bench for mem_stage_p against a behavioural model.
module tb_mem_stage_p;

    typedef struct {
        logic        v, stall, flush, rd, wr, br, zero, rw;
        logic [1:0]  be;
        logic [15:0] addr, data, spc;
        logic [2:0]  rdst;
    } stim_t;

    typedef struct {
        logic        valid, regWrite, err, pcsrc;
        logic [15:0] data, ula, spc;
        logic [2:0]  regDst;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        inValid = 0, stall = 0, flush = 0;
    logic        MemRead = 0, MemWrite = 0, Branch = 0, Zero = 0, RegWrite = 0;
    logic [1:0]  byteEn = 0;
    logic [15:0] resultULA = 0, writeDataMEM = 0, shiftPC = 0;
    logic [2:0]  RegDst = 0;
    logic        PCSrc, outValid, outRegWrite, addrError;
    logic [15:0] outputDataReadMEM, outputMemULA, outputShiftPC;
    logic [2:0]  outputRegDst;

    exp_t        q[$];
    exp_t        ex;
    exp_t        mon;
    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    mem_stage_p dut (
        .clock(clock), .resetN(resetN), .inValid(inValid), .stall(stall), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Zero(Zero),
        .RegWrite(RegWrite), .byteEn(byteEn), .resultULA(resultULA),
        .writeDataMEM(writeDataMEM), .shiftPC(shiftPC), .RegDst(RegDst), .PCSrc(PCSrc),
        .outValid(outValid), .outputDataReadMEM(outputDataReadMEM),
        .outputMemULA(outputMemULA), .outputShiftPC(outputShiftPC),
        .outputRegDst(outputRegDst), .outRegWrite(outRegWrite), .addrError(addrError)
    );

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chkReset(string tag);
        chk({tag, ".valid"}, 16'(outValid), 16'd0);
        chk({tag, ".regWrite"}, 16'(outRegWrite), 16'd0);
        chk({tag, ".addrError"}, 16'(addrError), 16'd0);
        chk({tag, ".data"}, outputDataReadMEM, 16'd0);
        chk({tag, ".ula"}, outputMemULA, 16'd0);
        chk({tag, ".spc"}, outputShiftPC, 16'd0);
        chk({tag, ".regDst"}, 16'(outputRegDst), 16'd0);
    endtask

    // Reference behaviour of one rising edge, applied to the model output slot and memory.
    task automatic modelEdge(stim_t s);
        logic inR;
        inR = s.addr < 16'd256;
        if (s.flush || (!s.stall && !s.v)) begin
            ex.valid = 0;
            ex.regWrite = 0;
            ex.err = 0;
        end else if (!s.stall) begin
            if (s.wr && inR)
                for (int i = 0; i < 2; i++) begin
`ifdef MEM_BYTE_WRITE_EN
                    if (s.be[i]) mem[s.addr[7:0]][8*i +: 8] = s.data[8*i +: 8];
`else
                    mem[s.addr[7:0]][8*i +: 8] = s.data[8*i +: 8];
`endif
                end
            ex.valid = 1;
            ex.regWrite = s.rw;
            ex.err = (s.rd || s.wr) && !inR;
            ex.data = (s.rd && inR) ? mem[s.addr[7:0]] : 16'd0;
            ex.ula = s.addr;
            ex.spc = s.spc;
            ex.regDst = s.rdst;
        end
    endtask

    // Drive one cycle of stimulus; queue what the DUT must show during this cycle.
    task automatic apply(stim_t s);
        inValid = s.v; stall = s.stall; flush = s.flush;
        MemRead = s.rd; MemWrite = s.wr; Branch = s.br; Zero = s.zero; RegWrite = s.rw;
        byteEn = s.be; resultULA = s.addr; writeDataMEM = s.data;
        shiftPC = s.spc; RegDst = s.rdst;
        ex.pcsrc = s.v & s.br & s.zero & ~s.flush;
        q.push_back(ex);
        @(posedge clock);
        #1;
        modelEdge(s);
    endtask

    function automatic stim_t op(logic r, logic w, logic [15:0] a, logic [15:0] d, logic [1:0] b);
        stim_t s;
        s = '{default: '0};
        s.v = 1; s.rd = r; s.wr = w; s.addr = a; s.data = d; s.be = b; s.rw = r;
        s.spc = 16'($urandom);
        s.rdst = 3'($urandom_range(0, 7));
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        int    sel;
        s = op(1'($urandom), 1'($urandom), 16'd0, 16'($urandom), 2'($urandom_range(0, 3)));
        sel = $urandom_range(0, 19);
        s.addr = sel < 14 ? 16'($urandom_range(0, 15)) :
                 sel < 17 ? 16'($urandom_range(0, 255)) : 16'($urandom_range(256, 65535));
        s.v = $urandom_range(0, 9) < 8;
        s.stall = $urandom_range(0, 9) < 2;
        s.flush = $urandom_range(0, 9) == 0;
        s.br = 1'($urandom);
        s.zero = 1'($urandom);
        s.rw = 1'($urandom);
        return s;
    endfunction

    task automatic resetPulse();
        resetN = 0;
        #1;
        chkReset("midReset");
        #1;
        resetN = 1;
        ex = '{default: '0};
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                mon = q.pop_front();
                chk("PCSrc", 16'(PCSrc), 16'(mon.pcsrc));
                chk("outValid", 16'(outValid), 16'(mon.valid));
                chk("outRegWrite", 16'(outRegWrite), 16'(mon.regWrite));
                chk("addrError", 16'(addrError), 16'(mon.err));
                if (mon.valid) begin
                    chk("readData", outputDataReadMEM, mon.data);
                    chk("memULA", outputMemULA, mon.ula);
                    chk("shiftPC", outputShiftPC, mon.spc);
                    chk("regDst", 16'(outputRegDst), 16'(mon.regDst));
                end
            end
        end
    end

    initial begin
        stim_t s;
        ex = '{default: '0};
        #1 resetN = 0;
        #2 chkReset("reset");
        #9 resetN = 1;
        @(posedge clock);
        #1;
        for (int a = 0; a < 256; a++) apply(op(0, 1, 16'(a), 16'($urandom), 2'b11));
        // load-after-store, write-first, out-of-range
        apply(op(0, 1, 16'h0010, 16'hBEEF, 2'b11));
        apply(op(1, 0, 16'h0010, 16'h0000, 2'b00));
        apply(op(1, 1, 16'h000F, 16'h0001, 2'b11));
        apply(op(1, 0, 16'h0100, 16'h0000, 2'b00));
        apply(op(0, 1, 16'h0100, 16'h5555, 2'b11));
        apply(op(1, 0, 16'h0000, 16'h0000, 2'b00));
        // branch decision, stall hold, flush over stall, bubble
        s = op(0, 0, 16'h0003, 16'h0000, 2'b00); s.br = 1; s.zero = 1; apply(s);
        s.zero = 0; apply(s);
        apply(op(1, 0, 16'h0010, 16'h0000, 2'b00));
        for (int i = 0; i < 3; i++) begin
            s = op(1, 1, 16'h0011, 16'h7777, 2'b11); s.stall = 1; s.br = 1; s.zero = 1;
            apply(s);
        end
        s.flush = 1; apply(s);
        s = op(1, 0, 16'h0011, 16'h0000, 2'b00); apply(s);
        s.v = 0; apply(s);
        // partial-lane store
        apply(op(0, 1, 16'h0020, 16'h1234, 2'b11));
        apply(op(0, 1, 16'h0020, 16'hABCD, 2'b01));
        apply(op(1, 0, 16'h0020, 16'h0000, 2'b00));
        apply(op(0, 1, 16'h0021, 16'h9999, 2'b00));
        apply(op(1, 0, 16'h0021, 16'h0000, 2'b00));
        for (int i = 0; i < 200; i++) apply(rnd());
        resetPulse();
        apply(op(0, 1, 16'h0033, 16'hC0DE, 2'b11));
        apply(op(1, 0, 16'h0033, 16'h0000, 2'b00));
        for (int i = 0; i < 200; i++) apply(rnd());
        repeat (3) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
